instruction_queue_register: RTL and testbench

Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction FIFO with valid/ready handshakes on both sides. It decodes the head entry into opcode/func, register-address and immediate fields, and supports selectable immediate extension. It sits between instruction memory fetch and the control unit / register file, so fetch can run ahead of decode in the multi-cycle processor.

---
 rtl/ir_pkg.sv | 35 +++
 rtl/ir_field_decode.sv | 67 ++++++
 rtl/instruction_queue_register.sv | 125 ++++++++++++
 tb/tb_instruction_queue_register.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared constants for the instruction queue register.
//   - imm_mode encodings IMM_RAW / IMM_SEXT / IMM_ZEXT / IMM_BR
//   - default widths and field offsets (derived from OPC_W and REG_W)
//   - helper functions that compute field offsets for any OPC_W/REG_W
package ir_pkg;

   localparam logic [1:0] IMM_RAW  = 2'b00;   // raw instruction word, zero-extended
   localparam logic [1:0] IMM_SEXT = 2'b01;   // imm field, sign-extended
   localparam logic [1:0] IMM_ZEXT = 2'b10;   // imm field, zero-extended
   localparam logic [1:0] IMM_BR   = 2'b11;   // imm field, sign-extended, shifted left 1

   localparam int IR_INSTR_W = 16;
   localparam int IR_OPC_W   = 7;
   localparam int IR_REG_W   = 3;
   localparam int IR_IMM_W   = 16;
   localparam int IR_DEPTH   = 4;

   function automatic int ir_regb_lo(input int opc_w);
      return opc_w;
   endfunction

   function automatic int ir_rega_lo(input int opc_w, input int reg_w);
      return opc_w + reg_w;
   endfunction

   // The immediate field starts where RegA starts (it overlaps RegA).
   function automatic int ir_immf_lo(input int opc_w, input int reg_w);
      return opc_w + reg_w;
   endfunction

   localparam int IR_REGB_LO = ir_regb_lo(IR_OPC_W);
   localparam int IR_REGA_LO = ir_rega_lo(IR_OPC_W, IR_REG_W);
   localparam int IR_IMMF_LO = ir_immf_lo(IR_OPC_W, IR_REG_W);

endpackage

// File: rtl/ir_field_decode.sv
// ir_field_decode: combinational decode of the queue head word.
// Ports:
//   i_head      in  INSTR_W  head instruction word
//   i_valid     in  1        head entry present; all outputs are 0 when low
//   i_imm_mode  in  2        immediate extension select (see ir_pkg)
//   o_control   out OPC_W    opcode+func field
//   o_rega      out REG_W    register A field
//   o_regb      out REG_W    register B field
//   o_regd      out REG_W    destination (same field as RegA)
//   o_imm       out IMM_W    extended immediate
module ir_field_decode
   import ir_pkg::*;
#(
   parameter int INSTR_W = IR_INSTR_W,
   parameter int OPC_W   = IR_OPC_W,
   parameter int REG_W   = IR_REG_W,
   parameter int IMM_W   = IR_IMM_W,
   parameter int REGB_LO = IR_REGB_LO,
   parameter int REGA_LO = IR_REGA_LO,
   parameter int IMMF_LO = IR_IMMF_LO
) (
   input  logic [INSTR_W-1:0] i_head,
   input  logic               i_valid,
   input  logic [1:0]         i_imm_mode,
   output logic [OPC_W-1:0]   o_control,
   output logic [REG_W-1:0]   o_rega,
   output logic [REG_W-1:0]   o_regb,
   output logic [REG_W-1:0]   o_regd,
   output logic [IMM_W-1:0]   o_imm
);

   localparam int IMMF_W = INSTR_W - IMMF_LO;

   logic [IMMF_W-1:0] w_immf;
   logic [IMM_W-1:0]  w_raw;
   logic [IMM_W-1:0]  w_sext;
   logic [IMM_W-1:0]  w_zext;
   logic [IMM_W-1:0]  w_br;

   assign w_immf = i_head[INSTR_W-1:IMMF_LO];
   assign w_raw  = IMM_W'(i_head);
   assign w_sext = {{(IMM_W-IMMF_W){w_immf[IMMF_W-1]}}, w_immf};
   assign w_zext = {{(IMM_W-IMMF_W){1'b0}}, w_immf};
   // Branch offset: sign-extended field scaled by 2, bit 0 forced low.
   assign w_br   = {w_sext[IMM_W-2:0], 1'b0};

   always_comb begin
      o_control = '0;
      o_rega    = '0;
      o_regb    = '0;
      o_regd    = '0;
      o_imm     = '0;
      if (i_valid) begin
         o_control = i_head[OPC_W-1:0];
         o_regb    = i_head[REGB_LO +: REG_W];
         o_rega    = i_head[REGA_LO +: REG_W];
         o_regd    = i_head[REGA_LO +: REG_W];
         case (i_imm_mode)
            IMM_RAW:  o_imm = w_raw;
            IMM_SEXT: o_imm = w_sext;
            IMM_ZEXT: o_imm = w_zext;
            default:  o_imm = w_br;
         endcase
      end
   end

endmodule

// File: rtl/instruction_queue_register.sv
// instruction_queue_register: DEPTH-entry instruction FIFO between fetch and
// decode, with valid/ready handshakes on both sides and a decoded head entry.
// Optional feature macro: IR_FLUSH_EN (adds input_IR_flush, synchronous clear).
// Ports:
//   CLK                in  1        clock, rising edge
//   Reset              in  1        asynchronous active-high reset
//   input_IR_valid     in  1        fetch presents an instruction
//   input_IR_ready     out 1        queue can accept (not full)
//   input_IR_Instru    in  INSTR_W  instruction word
//   input_IR_imm_mode  in  2        immediate extension select for the head
//   input_IR_flush     in  1        discard all entries (IR_FLUSH_EN only)
//   Output_IR_valid    out 1        head entry present (not empty)
//   Output_IR_ready    in  1        consumer takes the head entry
//   Output_IR_Control  out OPC_W    opcode+func field of the head
//   Output_IR_RegB     out REG_W    register B field of the head
//   Output_IR_RegA     out REG_W    register A field of the head
//   Output_IR_RegD     out REG_W    destination field (shares RegA bits)
//   Output_IR_Imm      out IMM_W    extended immediate of the head
//   Output_IR_count    out CNT_W    number of entries held
module instruction_queue_register
   import ir_pkg::*;
#(
   parameter int INSTR_W = IR_INSTR_W,
   parameter int OPC_W   = IR_OPC_W,
   parameter int REG_W   = IR_REG_W,
   parameter int IMM_W   = IR_IMM_W,
   parameter int DEPTH   = IR_DEPTH
) (
   input  logic                       CLK,
   input  logic                       Reset,
   input  logic                       input_IR_valid,
   output logic                       input_IR_ready,
   input  logic [INSTR_W-1:0]         input_IR_Instru,
   input  logic [1:0]                 input_IR_imm_mode,
`ifdef IR_FLUSH_EN
   input  logic                       input_IR_flush,
`endif
   output logic                       Output_IR_valid,
   input  logic                       Output_IR_ready,
   output logic [OPC_W-1:0]           Output_IR_Control,
   output logic [REG_W-1:0]           Output_IR_RegB,
   output logic [REG_W-1:0]           Output_IR_RegA,
   output logic [REG_W-1:0]           Output_IR_RegD,
   output logic [IMM_W-1:0]           Output_IR_Imm,
   output logic [$clog2(DEPTH+1)-1:0] Output_IR_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [INSTR_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // No pass-through: a full queue refuses a push even when a pop is
   // happening in the same cycle.
   assign w_push = input_IR_valid && !w_full;
   assign w_pop  = Output_IR_ready && !w_empty;

   assign input_IR_ready  = !w_full;
   assign Output_IR_valid = !w_empty;
   assign Output_IR_count = r_count;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end
`ifdef IR_FLUSH_EN
      else if (input_IR_flush) begin
         // Flush wins over any push/pop in the same cycle.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end
`endif
      else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= input_IR_Instru;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   ir_field_decode #(
      .INSTR_W (INSTR_W),
      .OPC_W   (OPC_W),
      .REG_W   (REG_W),
      .IMM_W   (IMM_W),
      .REGB_LO (ir_regb_lo(OPC_W)),
      .REGA_LO (ir_rega_lo(OPC_W, REG_W)),
      .IMMF_LO (ir_immf_lo(OPC_W, REG_W))
   ) u_decode (
      .i_head     (r_mem[r_rd_ptr]),
      .i_valid    (!w_empty),
      .i_imm_mode (input_IR_imm_mode),
      .o_control  (Output_IR_Control),
      .o_rega     (Output_IR_RegA),
      .o_regb     (Output_IR_RegB),
      .o_regd     (Output_IR_RegD),
      .o_imm      (Output_IR_Imm)
   );

endmodule

// File: tb/tb_instruction_queue_register.sv
// Testbench for instruction_queue_register (default parameters).
// A queue-based model holds the expected contents; the field/immediate
// expectations are computed arithmetically from the head word.
module tb_instruction_queue_register;

`ifdef IR_FLUSH_EN
   localparam bit FLUSH_PRESENT = 1'b1;
`else
   localparam bit FLUSH_PRESENT = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        Reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] instr;
   logic [1:0]  mode;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  ctrl;
   logic [2:0]  regb;
   logic [2:0]  rega;
   logic [2:0]  regd;
   logic [15:0] imm;
   logic [2:0]  count;

   int n_checks = 0;
   int n_err    = 0;
   bit check_en = 1'b0;

   logic [15:0] q [$];

   always #10 CLK = ~CLK;

   instruction_queue_register dut (
      .CLK               (CLK),
      .Reset             (Reset),
      .input_IR_valid    (in_valid),
      .input_IR_ready    (in_ready),
      .input_IR_Instru   (instr),
      .input_IR_imm_mode (mode),
`ifdef IR_FLUSH_EN
      .input_IR_flush    (flush),
`endif
      .Output_IR_valid   (out_valid),
      .Output_IR_ready   (out_ready),
      .Output_IR_Control (ctrl),
      .Output_IR_RegB    (regb),
      .Output_IR_RegA    (rega),
      .Output_IR_RegD    (regd),
      .Output_IR_Imm     (imm),
      .Output_IR_count   (count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Immediate from the top 6 bits of the head, as plain integer arithmetic.
   function automatic logic [15:0] m_imm(input logic [15:0] h, input logic [1:0] m);
      int f;
      int s;
      f = int'(h) / 1024;
      s = (f >= 32) ? f - 64 : f;
      case (m)
         2'd0:    return h;
         2'd1:    return 16'(s);
         2'd2:    return 16'(f);
         default: return 16'(s * 2);
      endcase
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge CLK) begin
      if (check_en && !Reset) begin
         automatic int          n = q.size();
         automatic logic [15:0] h = (n > 0) ? q[0] : 16'h0;
         automatic bit          v = (n > 0);
         chk("valid",   32'(out_valid), 32'(v));
         chk("ready",   32'(in_ready),  32'(n < 4));
         chk("count",   32'(count),     32'(n));
         chk("control", 32'(ctrl), v ? 32'(h % 128) : 32'h0);
         chk("regb",    32'(regb), v ? 32'((h / 128) % 8) : 32'h0);
         chk("rega",    32'(rega), v ? 32'((h / 1024) % 8) : 32'h0);
         chk("regd",    32'(regd), v ? 32'((h / 1024) % 8) : 32'h0);
         chk("imm",     32'(imm),  v ? 32'(m_imm(h, mode)) : 32'h0);
      end
   end

   // Drive one cycle of inputs, advance through the rising edge and apply
   // the same cycle to the model. Leaves time at posedge+1.
   task automatic step(input bit v, input logic [15:0] w, input logic [1:0] m,
                       input bit r, input bit f);
      bit do_push;
      bit do_pop;
      bit do_flush;
      in_valid  = v;
      instr     = w;
      mode      = m;
      out_ready = r;
      flush     = f;
      @(posedge CLK);
      do_flush = flush && FLUSH_PRESENT;
      do_push  = v && (q.size() < 4);
      do_pop   = r && (q.size() > 0);
      if (do_flush) begin
         q.delete();
      end else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(w);
      end
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"},   32'(out_valid), 32'h0);
      chk({tag, "_ready"},   32'(in_ready),  32'h1);
      chk({tag, "_count"},   32'(count),     32'h0);
      chk({tag, "_control"}, 32'(ctrl),      32'h0);
      chk({tag, "_regb"},    32'(regb),      32'h0);
      chk({tag, "_rega"},    32'(rega),      32'h0);
      chk({tag, "_regd"},    32'(regd),      32'h0);
      chk({tag, "_imm"},     32'(imm),       32'h0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] words [5];
      logic [1:0]  sw_mode [4];
      logic [15:0] sw_exp [4];
      words   = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F};
      sw_mode = '{2'b01, 2'b10, 2'b11, 2'b00};
      sw_exp  = '{16'hFFFF, 16'h003F, 16'hFFFE, 16'hFC00};

      Reset = 1'b1; in_valid = 1'b0; instr = '0; mode = '0;
      out_ready = 1'b0; flush = 1'b0;
      #2;
      chk_all_zero("reset");
      @(posedge CLK); #1;
      Reset = 1'b0;
      check_en = 1'b1;

      // First push: one-cycle latency, decoded fields of 16'hA5C3.
      step(1, 16'hA5C3, 2'b00, 0, 0);
      chk("a5c3_valid",   32'(out_valid), 32'h1);
      chk("a5c3_control", 32'(ctrl), 32'h43);
      chk("a5c3_regb",    32'(regb), 32'h3);
      chk("a5c3_rega",    32'(rega), 32'h1);
      chk("a5c3_regd",    32'(regd), 32'h1);
      chk("a5c3_imm",     32'(imm),  32'hA5C3);
      chk("a5c3_count",   32'(count), 32'h1);
      step(0, 16'h0, 2'b00, 1, 0);

      // imm_mode sweep is combinational on the head.
      step(1, 16'hFC00, 2'b00, 0, 0);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mode = sw_mode[i];
         #1;
         chk("imm_sweep", 32'(imm), 32'(sw_exp[i]));
      end
      step(0, 16'h0, 2'b00, 1, 0);

      // Fill past full, then drain in order.
      for (int i = 0; i < 5; i++) begin
         step(1, words[i], 2'b00, 0, 0);
         if (i == 3) begin
            chk("full_ready", 32'(in_ready), 32'h0);
            chk("full_count", 32'(count), 32'h4);
         end
      end
      chk("held_off_count", 32'(count), 32'h4);
      for (int i = 0; i < 4; i++) begin
         chk("pop_order", 32'(imm), 32'(words[i]));
         step(0, 16'h0, 2'b00, 1, 0);
      end
      chk("drained_valid", 32'(out_valid), 32'h0);

      // Full with both sides active: pop only, then a push is accepted.
      for (int i = 0; i < 4; i++) step(1, words[i], 2'b00, 0, 0);
      step(1, 16'h7777, 2'b00, 1, 0);
      chk("full_both_count", 32'(count), 32'h3);
      step(1, 16'h8888, 2'b00, 0, 0);
      chk("refill_count", 32'(count), 32'h4);
      for (int i = 0; i < 4; i++) step(0, 16'h0, 2'b00, 1, 0);

      // Empty with push and pop together: the word is kept.
      step(1, 16'h4321, 2'b00, 1, 0);
      chk("empty_both_count", 32'(count), 32'h1);
      chk("empty_both_imm",   32'(imm), 32'h4321);
      step(0, 16'h0, 2'b00, 1, 0);

      // Pointer wrap over 10 rounds.
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) step(1, 16'(r * 16'h0111 + k * 16'h1003), 2'(k), 0, 0);
         for (int k = 0; k < 3; k++) step(0, 16'h0, 2'(k + 1), 1, 0);
      end

`ifdef IR_FLUSH_EN
      for (int i = 0; i < 3; i++) step(1, words[i], 2'b00, 0, 0);
      chk("pre_flush_count", 32'(count), 32'h3);
      step(1, 16'hBEEF, 2'b00, 0, 1);
      chk("flush_count",   32'(count), 32'h0);
      chk("flush_valid",   32'(out_valid), 32'h0);
      chk("flush_control", 32'(ctrl), 32'h0);
      chk("flush_imm",     32'(imm), 32'h0);
`endif

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         step(bit'($urandom_range(0, 1)), 16'($urandom()), 2'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
      end

      // Reset mid-stream, away from any clock edge.
      step(1, 16'h3C5A, 2'b01, 0, 0);
      step(1, 16'hC3A5, 2'b01, 0, 0);
      #2;
      Reset = 1'b1;
      #1;
      chk_all_zero("midreset");
      q.delete();
      @(posedge CLK); #1;
      Reset = 1'b0;

      for (int i = 0; i < 300; i++) begin
         step(bit'($urandom_range(0, 1)), 16'($urandom()), 2'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)), 1'b0);
      end

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
